led_pwm_drv: RTL and testbench

LED_PWM_DRV -- requirements
Module: led_pwm_drv

---
 rtl/led_pwm_drv_pkg.sv | 13 +
 rtl/led_pwm_drv_gamma.sv | 22 ++
 rtl/led_pwm_drv.sv | 113 +++++++++++
 tb/tb_led_pwm_drv.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/led_pwm_drv_pkg.sv
// Shared LED definitions: PWM period geometry and the driver state encoding.
package led_pwm_drv_pkg;

  // 255 steps per PWM period, counter runs 0..PWM_MAX.
  localparam int PWM_STEPS = 255;
  localparam int PWM_MAX   = PWM_STEPS - 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } led_state_e;

endpackage

// File: rtl/led_pwm_drv_gamma.sv
// Brightness-to-duty mapping: square law with round-up, or pass-through.
module led_gamma
  import led_pwm_drv_pkg::*;
#(
  parameter bit GAMMA_EN = 1'b1
) (
  input  logic [7:0] lvl_i,
  output logic [7:0] duty_o
);

  if (GAMMA_EN) begin : g_sq
    logic [15:0] sq;
    logic [15:0] sum;
    // +255 before the shift rounds up, so any nonzero level stays visible.
    assign sq     = 16'(lvl_i) * 16'(lvl_i);
    assign sum    = sq + 16'd255;
    assign duty_o = sum[15:8];
  end else begin : g_lin
    assign duty_o = lvl_i;
  end

endmodule

// File: rtl/led_pwm_drv.sv
// LED PWM driver: level handshake into a one-deep shadow, duty swapped only
// at period wrap (or while idle), prescaled 255-step PWM, registered output.
module led_pwm_drv
  import led_pwm_drv_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 1,
  parameter bit          GAMMA_EN   = 1'b1,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic       s_clk,
  input  logic       s_rst,
  input  logic       en,
  input  logic [7:0] lvl,
  input  logic       lvl_valid,
  output logic       lvl_ready,
  output logic       led,
  output logic       period_end
);

  localparam logic [15:0] PSC_LAST = 16'(CLK_DIV - 1);
  localparam logic [7:0]  CNT_LAST = 8'(PWM_MAX);
  localparam logic        LED_OFF  = ACTIVE_LOW;

  led_state_e  state_q, state_d;
  logic [15:0] psc_q, psc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  duty_q, duty_d;
  logic [7:0]  shadow_q, shadow_d;
  logic        shadow_full_q, shadow_full_d;
  logic        led_q, led_d;
  logic        pe_q, pe_d;

  logic [7:0]  mapped;
  logic        run, tick, wrap, hs, lit;

  led_gamma #(.GAMMA_EN(GAMMA_EN)) u_gamma (
    .lvl_i  (lvl),
    .duty_o (mapped)
  );

  // en is re-evaluated every cycle; the state just follows it.
  always_comb begin
    state_d = state_q;
    if (en) state_d = ST_RUN;
    else    state_d = ST_IDLE;
  end

  // Counters, duty/shadow bookkeeping and registered outputs.
  always_comb begin
    psc_d         = psc_q;
    cnt_d         = cnt_q;
    duty_d        = duty_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;

    // A falling en acts on the very next edge, so it gates RUN behaviour.
    run  = (state_q == ST_RUN) && en;
    tick = run && (psc_q == PSC_LAST);
    wrap = tick && (cnt_q == CNT_LAST);
    hs   = lvl_valid && !shadow_full_q;
    lit  = run && (cnt_q < duty_q);

    if (run) begin
      psc_d = tick ? 16'd0 : psc_q + 16'd1;
      if (tick) cnt_d = wrap ? 8'd0 : cnt_q + 8'd1;
    end else begin
      psc_d = 16'd0;
      cnt_d = 8'd0;
    end

    // Duty may only change at a period boundary or while idle.
    if (shadow_full_q && (!run || wrap)) begin
      duty_d        = shadow_q;
      shadow_full_d = 1'b0;
    end else if (hs && wrap) begin
      duty_d = mapped;
    end else if (hs) begin
      shadow_d      = mapped;
      shadow_full_d = 1'b1;
    end

    led_d = ACTIVE_LOW ? ~lit : lit;
    pe_d  = wrap;
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge s_clk or negedge s_rst) begin
    if (!s_rst) begin
      state_q       <= ST_IDLE;
      psc_q         <= '0;
      cnt_q         <= '0;
      duty_q        <= '0;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      led_q         <= LED_OFF;
      pe_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      psc_q         <= psc_d;
      cnt_q         <= cnt_d;
      duty_q        <= duty_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      led_q         <= led_d;
      pe_q          <= pe_d;
    end
  end

  assign lvl_ready  = !shadow_full_q;
  assign led        = led_q;
  assign period_end = pe_q;

endmodule

// File: tb/tb_led_pwm_drv.sv
// Bench for led_pwm_drv: three configurations share one stimulus stream and
// are compared every cycle against a time-based reference model.
module tb_led_pwm_drv;

  localparam int N = 3;
  localparam int DIV [N] = '{1, 4, 2};
  localparam bit GAM [N] = '{1'b0, 1'b0, 1'b1};
  localparam bit ALO [N] = '{1'b1, 1'b0, 1'b1};

  logic s_clk = 1'b0, s_rst = 1'b0, en = 1'b0, lvl_valid = 1'b0;
  logic [7:0] lvl = 8'd0;
  logic [N-1:0] led_w, rdy_w, pe_w;

  int n_vec = 0, n_err = 0;
  bit chk_on = 1'b0;

  always #5 s_clk = ~s_clk;

  led_pwm_drv #(.CLK_DIV(1), .GAMMA_EN(1'b0), .ACTIVE_LOW(1'b1)) u_dut0 (
    .s_clk(s_clk), .s_rst(s_rst), .en(en), .lvl(lvl), .lvl_valid(lvl_valid),
    .lvl_ready(rdy_w[0]), .led(led_w[0]), .period_end(pe_w[0]));
  led_pwm_drv #(.CLK_DIV(4), .GAMMA_EN(1'b0), .ACTIVE_LOW(1'b0)) u_dut1 (
    .s_clk(s_clk), .s_rst(s_rst), .en(en), .lvl(lvl), .lvl_valid(lvl_valid),
    .lvl_ready(rdy_w[1]), .led(led_w[1]), .period_end(pe_w[1]));
  led_pwm_drv #(.CLK_DIV(2), .GAMMA_EN(1'b1), .ACTIVE_LOW(1'b1)) u_dut2 (
    .s_clk(s_clk), .s_rst(s_rst), .en(en), .lvl(lvl), .lvl_valid(lvl_valid),
    .lvl_ready(rdy_w[2]), .led(led_w[2]), .period_end(pe_w[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: position in the period is derived from elapsed run time.
  bit m_run [N];
  int m_t [N];
  int m_duty [N];
  bit m_sf [N];
  int m_sv [N];
  bit m_led [N];
  bit m_pe [N];

  function automatic int map_lvl(int d, int l);
    return GAM[d] ? (l * l + 255) / 256 : l;
  endfunction

  initial for (int d = 0; d < N; d++) m_led[d] = ALO[d];

  always @(posedge s_clk or negedge s_rst) begin
    bit run, wrap, hs;
    int step;
    for (int d = 0; d < N; d++) begin
      if (!s_rst) begin
        m_run[d] = 0; m_t[d] = 0; m_duty[d] = 0; m_sf[d] = 0;
        m_sv[d] = 0; m_led[d] = ALO[d]; m_pe[d] = 0;
      end else begin
        run  = m_run[d] && en;
        step = (m_t[d] / DIV[d]) % 255;
        wrap = run && ((m_t[d] + 1) % (255 * DIV[d]) == 0);
        hs   = lvl_valid && !m_sf[d];
        m_led[d] = (run && step < m_duty[d]) ? !ALO[d] : ALO[d];
        m_pe[d]  = wrap;
        // A waiting level goes live at period start or whenever idle.
        if (m_sf[d] && (!run || wrap)) begin
          m_duty[d] = m_sv[d]; m_sf[d] = 0;
        end else if (hs && wrap) begin
          m_duty[d] = map_lvl(d, int'(lvl));
        end else if (hs) begin
          m_sv[d] = map_lvl(d, int'(lvl)); m_sf[d] = 1;
        end
        m_t[d]   = run ? m_t[d] + 1 : 0;
        m_run[d] = en;
      end
    end
  end

  always @(negedge s_clk) begin
    if (chk_on) begin
      for (int d = 0; d < N; d++) begin
        check($sformatf("led%0d", d), led_w[d], m_led[d]);
        check($sformatf("pe%0d", d), pe_w[d], m_pe[d]);
        check($sformatf("rdy%0d", d), rdy_w[d], !m_sf[d]);
      end
    end
  end

  task automatic load(input int l);
    lvl = 8'(l); lvl_valid = 1'b1;
    @(negedge s_clk);
    lvl_valid = 1'b0;
  endtask

  task automatic wait_pe(input int d, output bit ok);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge s_clk);
      if (pe_w[d]) begin ok = 1; break; end
    end
  endtask

  // Skip the period in which a new duty lands, then count one full period.
  task automatic measure(input int d, input int exp_lit, input string tag);
    bit ok;
    int lit, len;
    wait_pe(d, ok);
    if (ok) wait_pe(d, ok);
    if (!ok) begin check({tag, "_timeout"}, 0, 1); return; end
    lit = 0; len = 0;
    do begin
      if (led_w[d] !== ALO[d]) lit++;
      len++;
      @(negedge s_clk);
    end while (!pe_w[d] && len < 3000);
    check({tag, "_lit"}, lit, exp_lit);
    check({tag, "_len"}, len, 255 * DIV[d]);
  endtask

  initial begin
    bit ok;
    int lit;
    repeat (3) @(negedge s_clk);
    for (int d = 0; d < N; d++) begin
      check($sformatf("rst_led%0d", d), led_w[d], ALO[d]);
      check($sformatf("rst_rdy%0d", d), rdy_w[d], 1);
      check($sformatf("rst_pe%0d", d), pe_w[d], 0);
    end
    s_rst = 1'b1; chk_on = 1'b1;
    repeat (3) @(negedge s_clk);
    check("idle_led0", led_w[0], 1);

    // Level loaded while idle, then run.
    load(100);
    en = 1'b1;
    measure(0, 100, "a_l100");
    measure(1, 400, "b_l100");
    measure(2, 40 * 2, "c_l100");

    // Gamma endpoints.
    load(128); measure(2, 64 * 2, "c_l128");
    load(1);   measure(2, 1 * 2, "c_l1");
    load(255); measure(2, 255 * 2, "c_l255");
    measure(0, 255, "a_l255");

    // Mid-period reload: old duty holds to the wrap, a second offer is dropped.
    load(50);
    wait_pe(0, ok); wait_pe(0, ok);
    repeat (100) @(negedge s_clk);
    load(200);
    check("a_busy", rdy_w[0], 0);
    load(77);
    measure(0, 200, "a_l200");

    // Handshake on the exact wrap cycle goes straight to the new period.
    wait_pe(0, ok);
    repeat (254) @(negedge s_clk);
    lvl = 8'd30; lvl_valid = 1'b1;
    @(negedge s_clk);
    lvl_valid = 1'b0;
    check("a_wrap_pe", pe_w[0], 1);
    check("a_wrap_rdy", rdy_w[0], 1);
    lit = 0;
    for (int i = 0; i < 254; i++) begin
      @(negedge s_clk);
      if (led_w[0] === 1'b0) lit++;
    end
    check("a_wrap_lit", lit, 30);

    // en dropped mid-period.
    repeat (37) @(negedge s_clk);
    en = 1'b0;
    @(negedge s_clk);
    for (int d = 0; d < N; d++) begin
      check($sformatf("off_led%0d", d), led_w[d], ALO[d]);
      check($sformatf("off_pe%0d", d), pe_w[d], 0);
    end
    en = 1'b1;

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) en = ~en;
      lvl_valid = ($urandom_range(0, 15) == 0);
      lvl = 8'($urandom);
      @(negedge s_clk);
    end
    lvl_valid = 1'b0;

    // Asynchronous reset in the middle of a cycle.
    en = 1'b1; load(180);
    repeat (600) @(negedge s_clk);
    #2 s_rst = 1'b0;
    #1;
    for (int d = 0; d < N; d++) begin
      check($sformatf("arst_led%0d", d), led_w[d], ALO[d]);
      check($sformatf("arst_rdy%0d", d), rdy_w[d], 1);
      check($sformatf("arst_pe%0d", d), pe_w[d], 0);
    end
    @(negedge s_clk);
    s_rst = 1'b1;
    repeat (20) @(negedge s_clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
